regfile_wb_stage: RTL and testbench
===================================

# regfile_wb_stage

Writeback stage feeding the 32x32 register-file RAM write port. Collects results from two producers, the ALU and the load unit, and buffers ALU results in a small FIFO. Loads always win the port. Emits exactly one registered write per cycle as we / prt_en0 / address_0 / data_0 toward the register file. Exports a pending-destination mask so the issue logic can interlock read-after-write and write-ordering hazards.

## Interface
- DEPTH, 4: ALU result FIFO entries; power of two, ≥2
- XLEN, 32: data width

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  stage can accept ALU result this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result present; no backpressure, always accepted
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- we  out  1  register-file write enable (registered)
- prt_en0  out  1  register-file write-port enable; identical to we
- address_0  out  5  write address (registered)
- data_0  out  XLEN  write data (registered)
- pend_mask  out  32  bit r set while any valid FIFO entry targets register r
- fifo_count  out  $clog2(DEPTH)+1  valid FIFO entries
- ord_err  out  1  sticky protocol-violation flag

## Operation
- Reset (async, while rst=1):
  - we, prt_en0, address_0, data_0, ord_err = 0
  - FIFO empty, fifo_count = 0, pend_mask = 0
  - alu_ready forced 0
- ALU accept: handshake when alu_valid && alu_ready.
  - alu_rd = 0: accepted, then discarded. Not enqueued, never written.
  - Otherwise enqueue {rd, data} at the tail.
- alu_ready = !rst && (fifo_count < DEPTH). Depends only on the registered count, never on the same-cycle pop.
- Write-port select each cycle, priority order:
  1. ld_valid && ld_rd ≠ 0: write the load.
  2. else FIFO non-empty: pop the head and write it.
  3. else no write.
- ld_valid with ld_rd = 0: dropped. In that cycle the FIFO head may pop.
- A selected write registers we = prt_en0 = 1 with address_0 / data_0 at the next edge. With no write, we = prt_en0 = 0 and address_0 / data_0 hold their previous values.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Push into an empty FIFO: the entry cannot pop in the same cycle (no fall-through).
- Full FIFO: alu_ready = 0. A pop that cycle raises alu_ready the following cycle.
- pend_mask is combinational from valid FIFO storage. Bits clear in the cycle after the entry pops.
- Ordering rule (upstream obligation): issue must not present ld_valid with a nonzero ld_rd whose pend_mask bit is set. On violation the load is still written first and ord_err sets to 1, held until reset.
- ALU starvation under continuous loads is permitted. The FIFO fills and alu_ready stays low.

## Timing
- Load latency: ld_valid in cycle N → we = 1 in cycle N+1.
- ALU latency, FIFO empty and no load: accepted in cycle N → popped in N+1 → we = 1 in N+2.
- Throughput: one register-file write per cycle, sustained.
- fifo_count and pend_mask update on the clock edge after push/pop.
- Reset asserted mid-operation: outputs clear immediately and FIFO contents are lost. First accept is possible in the first cycle after rst deasserts.

## Test plan
- Reset: hold rst with alu_valid=1 → alu_ready=0, we=0, fifo_count=0. Deassert → alu_ready=1.
- Single ALU write: alu rd=5, data=0xDEADBEEF in cycle N → we=prt_en0=1, address_0=5, data_0=0xDEADBEEF in N+2; pend_mask[5]=1 only in N+1.
- Load priority:
  - Preload FIFO with rd=3 (0x11).
  - Load rd=7 (0x22) on the cycle the head would pop.
  - → load written first, then rd=3 write next cycle.
  - → fifo_count never exceeds 1.
- Full/wrap, DEPTH=4:
  - Continuous loads (rd=1) while pushing ALU rd=8..11 → alu_ready drops after 4 accepts.
  - Stop loads → writes 8, 9, 10, 11 in order on consecutive cycles.
  - Repeat 3 times to exercise pointer wrap.
- x0 drop: alu_rd=0 and ld_rd=0 with data 0xFFFFFFFF → no we pulse, fifo_count stays 0.
- Ordering violation: FIFO holds rd=9, then ld_valid with ld_rd=9 → load written first, ord_err=1 sticky until rst.

Source files
------------

// File: rtl/regfile_wb_stage_if.sv
// Bundle between the writeback stage and its neighbours: ALU and load producers on the
// input side, register-file write port and hazard status on the output side.
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   ld_valid/ld_rd/ld_data              : load result, always accepted
//   we/prt_en0/address_0/data_0         : registered register-file write
//   pend_mask/fifo_count/ord_err        : hazard and status outputs
interface regfile_wb_stage_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            we;
    logic            prt_en0;
    logic [4:0]      address_0;
    logic [XLEN-1:0] data_0;
    logic [31:0]     pend_mask;
    logic [CntW-1:0] fifo_count;
    logic            ord_err;

    // Producer / observer side.
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, we, prt_en0, address_0, data_0, pend_mask, fifo_count, ord_err
    );

    // Writeback stage side.
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, we, prt_en0, address_0, data_0, pend_mask, fifo_count, ord_err
    );
endinterface

// File: rtl/regfile_wb_stage.sv
// Writeback stage: arbitrates the single register-file write port between loads (always
// win) and ALU results buffered in a DEPTH-entry FIFO. One registered write per cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : regfile_wb_stage_if slave modport (handshakes, write port, status)
module regfile_wb_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_stage_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]      rd_mem_q  [DEPTH];
    logic [XLEN-1:0] dat_mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [4:0]       addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             ord_err_q, ord_err_d;

    logic        alu_ready;
    logic        push;
    logic        pop;
    logic        ld_sel;
    logic [31:0] pend_mask;

    // Handshake and port selection. Ready looks only at the registered count so a pop in
    // the same cycle never opens a slot combinationally.
    always_comb begin
        alu_ready = !rst && (cnt_q < CntW'(DEPTH));
        push      = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
        ld_sel    = bus.ld_valid && (bus.ld_rd != 5'd0);
        pop       = !ld_sel && (cnt_q != '0);
    end

    // Pending destinations come from valid storage, so a popped entry drops out after
    // the edge that retires it.
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_mask[rd_mem_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        we_d      = ld_sel || pop;
        addr_d    = addr_q;
        data_d    = data_q;
        vld_d     = vld_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ord_err_d = ord_err_q || (ld_sel && pend_mask[bus.ld_rd]);

        if (ld_sel) begin
            addr_d = bus.ld_rd;
            data_d = bus.ld_data;
        end else if (pop) begin
            addr_d = rd_mem_q[rd_ptr_q];
            data_d = dat_mem_q[rd_ptr_q];
        end

        // Push and pop slots never coincide: equal pointers mean empty (no pop) or full
        // (no push).
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ord_err_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ord_err_q <= ord_err_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]  <= bus.alu_rd;
            dat_mem_q[wr_ptr_q] <= bus.alu_data;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.we         = we_q;
    assign bus.prt_en0    = we_q;
    assign bus.address_0  = addr_q;
    assign bus.data_0     = data_q;
    assign bus.pend_mask  = pend_mask;
    assign bus.fifo_count = cnt_q;
    assign bus.ord_err    = ord_err_q;
endmodule

// File: tb/tb_regfile_wb_stage.sv
module tb_regfile_wb_stage;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // Reference model: an ordered list of buffered ALU results plus the last write.
    ent_t        mq[$];
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_ord;

    regfile_wb_stage_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    regfile_wb_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".we"},         32'(bus.we),         32'(exp_we));
        check({tag, ".prt_en0"},    32'(bus.prt_en0),    32'(exp_we));
        check({tag, ".address_0"},  32'(bus.address_0),  32'(exp_addr));
        check({tag, ".data_0"},     bus.data_0,          exp_data);
        check({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(mq.size()));
        check({tag, ".pend_mask"},  bus.pend_mask,       model_pend());
        check({tag, ".ord_err"},    32'(bus.ord_err),    32'(exp_ord));
    endtask

    // One clock of stimulus; inputs change 1 time unit after a rising edge.
    task automatic cycle(input string tag,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        ent_t e;
        logic rdy;
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lr;
        bus.ld_data   = ld;
        #1;
        rdy = (mq.size() < DEPTH);
        check({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(rdy));
        if (lv && lr != 5'd0) begin
            if (model_pend()[lr]) exp_ord = 1'b1;
            exp_we   = 1'b1;
            exp_addr = lr;
            exp_data = ld;
        end else if (mq.size() > 0) begin
            e        = mq.pop_front();
            exp_we   = 1'b1;
            exp_addr = e.rd;
            exp_data = e.d;
        end else begin
            exp_we = 1'b0;
        end
        if (av && rdy && ar != 5'd0) begin
            e.rd = ar;
            e.d  = ad;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Assert reset asynchronously (between edges) with an ALU offer held high.
    task automatic do_reset(input string tag);
        rst           = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.ld_valid  = 1'b0;
        mq.delete();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_ord  = 1'b0;
        #1;
        check({tag, ".rst_ready"}, 32'(bus.alu_ready), 32'd0);
        check_outputs({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".hold_ready"}, 32'(bus.alu_ready), 32'd0);
        check_outputs({tag, ".hold"});
        rst           = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        check({tag, ".rel_ready"}, 32'(bus.alu_ready), 32'd1);
    endtask

    initial begin
        logic        av, lv;
        logic [4:0]  ar, lr;
        logic [31:0] ad, ldv;
        n_tests = 0;
        n_fail  = 0;
        rst           = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // Single ALU write: visible two cycles after accept, pend bit only in between.
        cycle("alu1", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("alu1.pend5", bus.pend_mask, 32'h0000_0020);
        idle("alu1.w");
        check("alu1.addr5", 32'(bus.address_0), 32'd5);
        idle("alu1.done");

        // Load wins the port over a waiting FIFO head.
        cycle("prio.push", 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        cycle("prio.ld", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
        check("prio.ld_addr", 32'(bus.address_0), 32'd7);
        idle("prio.alu");
        check("prio.alu_addr", 32'(bus.address_0), 32'd3);
        idle("prio.done");

        // Fill under continuous loads, check stall, then drain in order; repeat for wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++)
                cycle("full.fill", 1'b1, 5'(8 + k), 32'(32'h100 * r + k), 1'b1, 5'd1, 32'(k));
            cycle("full.stall", 1'b1, 5'd12, 32'hBAD, 1'b1, 5'd1, 32'h5);
            check("full.count", 32'(bus.fifo_count), 32'd4);
            for (int k = 0; k < 4; k++) begin
                idle("full.drain");
                check("full.order", 32'(bus.address_0), 32'(8 + k));
            end
            idle("full.empty");
        end

        // Writes to x0 vanish from both producers.
        cycle("x0", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
        check("x0.we", 32'(bus.we), 32'd0);
        idle("x0.after");
        check("x0.count", 32'(bus.fifo_count), 32'd0);

        // Ordering violation: load to a pending destination still goes first, flag sticks.
        cycle("ord.push", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        cycle("ord.ld", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77);
        check("ord.flag", 32'(bus.ord_err), 32'd1);
        check("ord.first", bus.data_0, 32'h77);
        repeat (3) idle("ord.sticky");
        check("ord.held", 32'(bus.ord_err), 32'd1);
        do_reset("ord.reset");

        // Randomized traffic against the model; small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            av  = ($urandom_range(0, 3) != 0);
            ar  = 5'($urandom_range(0, 7));
            ad  = $urandom;
            lv  = ($urandom_range(0, 2) == 0);
            lr  = 5'($urandom_range(0, 7));
            ldv = $urandom;
            cycle("rand", av, ar, ad, lv, lr, ldv);
        end

        // Reset mid-operation with entries buffered.
        cycle("mid.push", 1'b1, 5'd20, 32'hAA, 1'b1, 5'd21, 32'hBB);
        cycle("mid.push2", 1'b1, 5'd22, 32'hCC, 1'b1, 5'd23, 32'hDD);
        do_reset("mid.reset");
        cycle("mid.accept", 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        idle("mid.write");
        check("mid.addr", 32'(bus.address_0), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
